// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive slave.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 8;
   localparam logic SPI_IDLE_LVL = 1'b1;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage 1-bit synchroniser; resets to the idle SPI line level.
module spi_sync
   import spi_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= {STAGES{SPI_IDLE_LVL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive slave: oversampled sck/mosi/cs, MSB-first deserialiser,
// valid/ready holding register with overrun and short-frame reporting.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              mosi,
   input  logic              cs,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic sck_s, mosi_s, cs_s;
   logic sck_p, cs_p;
   logic sck_fall, cs_rise, sample;

   spi_rx_state_t state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-2:0] shift, shift_nxt;
   logic [DATA_W-1:0] word_next;
   logic [DATA_W-1:0] rx_data_nxt;
   logic              rx_valid_nxt, overrun_nxt, frame_err_nxt, word_done;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs),   .q(cs_s));

   // Delayed copies of the synchronised lines for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_p <= SPI_IDLE_LVL;
         cs_p  <= SPI_IDLE_LVL;
      end else begin
         sck_p <= sck_s;
         cs_p  <= cs_s;
      end
   end

   // The falling sck that coincides with cs falling is not a data sample
   assign sck_fall  = ~sck_s & sck_p;
   assign cs_rise   = cs_s & ~cs_p;
   assign sample    = sck_fall & ~cs_s & ~cs_p;
   assign word_next = {shift, mosi_s};
   assign busy      = ~cs_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift     <= shift_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         overrun   <= overrun_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      shift_nxt     = shift;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = rx_valid;
      overrun_nxt   = 1'b0;
      frame_err_nxt = 1'b0;
      word_done     = 1'b0;

      if (rx_valid && rx_ready) begin
         rx_valid_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            if (!cs_s) begin
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_nxt = IDLE;
               if (cnt != '0) begin
                  frame_err_nxt = 1'b1;
               end
               cnt_nxt   = '0;
               shift_nxt = '0;
            end else if (sample) begin
               shift_nxt = word_next[DATA_W-2:0];
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  word_done = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A full holding register only takes a new word if it is drained this cycle
      if (word_done) begin
         if (!rx_valid || rx_ready) begin
            rx_data_nxt  = word_next;
            rx_valid_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: master-style pin driver plus a pin-level
// behavioural model of word delivery, errors and the holding register.
module tb_spi_slave_rx;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;

   logic       clk = 1'b0;
   logic       reset, sck, mosi, cs, rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, overrun, frame_err, busy;

   spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs(cs),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overrun(overrun), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state and scheduled output events keyed by clock edge index
   logic [7:0] m_data;
   logic       m_valid, m_ov, m_fe, m_busy;
   logic [7:0] ev_word [int];
   bit         ev_fe   [int];
   bit         ev_busy [int];
   logic       last_sck, last_cs;
   int         nbits;
   logic [7:0] acc;
   int         n_valid, n_ov, n_fe;
   bit         rand_ready = 1'b0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("rx_data",   rx_data,         m_data);
      chk("rx_valid",  8'(rx_valid),    8'(m_valid));
      chk("overrun",   8'(overrun),     8'(m_ov));
      chk("frame_err", 8'(frame_err),   8'(m_fe));
      chk("busy",      8'(busy),        8'(m_busy));
      chk("ov_fe_excl", 8'(overrun & frame_err), 8'd0);
      if (rx_valid === 1'b1) n_valid++;
      if (overrun === 1'b1) n_ov++;
      if (frame_err === 1'b1) n_fe++;
   endtask

   task automatic clr_cnt();
      n_valid = 0;
      n_ov    = 0;
      n_fe    = 0;
   endtask

   // classify the pin values presented to the coming edge
   task automatic pin_eval();
      if (reset) begin
         ev_busy[cyc + SYNC] = ~cs;
         if (last_sck && !sck && !cs && !last_cs) begin
            acc = {acc[6:0], mosi};
            nbits++;
            if (nbits == 8) begin
               ev_word[cyc + LAT] = acc;
               nbits = 0;
            end
         end
         if (!last_cs && cs) begin
            if (nbits != 0) ev_fe[cyc + LAT] = 1'b1;
            nbits = 0;
         end
      end
      last_sck = sck;
      last_cs  = cs;
   endtask

   task automatic model_update();
      if (!reset) begin
         m_data = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
      end else begin
         m_ov = 1'b0;
         m_fe = 1'b0;
         if (ev_busy.exists(cyc)) begin
            m_busy = ev_busy[cyc];
            ev_busy.delete(cyc);
         end
         if (ev_fe.exists(cyc)) begin
            m_fe = 1'b1;
            ev_fe.delete(cyc);
         end
         if (ev_word.exists(cyc)) begin
            if (!m_valid || rx_ready) begin
               m_data  = ev_word[cyc];
               m_valid = 1'b1;
            end else begin
               m_ov = 1'b1;
            end
            ev_word.delete(cyc);
         end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step();
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
      pin_eval();
      @(posedge clk);
      cyc++;
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   // one cs window carrying n bits MSB first; optional rx_ready pulse on the completion edge
   task automatic send(input logic [15:0] bits, input int n, input bit pulse);
      cs = 1'b0; sck = 1'b0; step();
      for (int i = 0; i < n; i++) begin
         sck = 1'b1; mosi = bits[n-1-i]; step();
         sck = 1'b0; step();
      end
      sck = 1'b1; step();
      cs = 1'b1;
      if (pulse) rx_ready = 1'b1;
      step();
      if (pulse) rx_ready = 1'b0;
      repeat (4) step();
   endtask

   task automatic assert_reset();
      reset = 1'b0; sck = 1'b1; cs = 1'b1; mosi = 1'b0;
      m_data = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
      ev_word.delete(); ev_fe.delete(); ev_busy.delete();
      nbits = 0; last_sck = 1'b1; last_cs = 1'b1;
      #1;
      check_outputs();
   endtask

   initial begin
      reset = 1'b0; sck = 1'b1; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
      m_data = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
      last_sck = 1'b1; last_cs = 1'b1; nbits = 0; acc = 8'h00;
      clr_cnt();
      repeat (3) step();
      chk("reset_data", rx_data, 8'h00);
      reset = 1'b1;
      repeat (3) step();

      // single frame, consumer always ready
      rx_ready = 1'b1; clr_cnt();
      send(16'h00A5, 8, 1'b0);
      chk("t1_data", rx_data, 8'hA5);
      chk("t1_nvalid", 8'(n_valid), 8'd1);
      chk("t1_nerr", 8'(n_fe + n_ov), 8'd0);

      // short frame then a full one
      clr_cnt();
      send(16'h0016, 5, 1'b0);
      chk("t2_nfe", 8'(n_fe), 8'd1);
      chk("t2_nvalid_partial", 8'(n_valid), 8'd0);
      clr_cnt();
      send(16'h003C, 8, 1'b0);
      chk("t2_data", rx_data, 8'h3C);
      chk("t2_nfe_full", 8'(n_fe), 8'd0);

      // overrun with consumer stalled
      rx_ready = 1'b0; clr_cnt();
      send(16'h0011, 8, 1'b0);
      send(16'h0022, 8, 1'b0);
      chk("t3_data", rx_data, 8'h11);
      chk("t3_nov", 8'(n_ov), 8'd1);
      rx_ready = 1'b1; step();
      rx_ready = 1'b0; step();
      chk("t3_drained", 8'(rx_valid), 8'd0);

      // consume and reload in the same cycle
      clr_cnt();
      send(16'h0011, 8, 1'b0);
      send(16'h0022, 8, 1'b1);
      chk("t4_data", rx_data, 8'h22);
      chk("t4_valid", 8'(rx_valid), 8'd1);
      chk("t4_nov", 8'(n_ov), 8'd0);
      rx_ready = 1'b1; repeat (2) step();

      // two words back to back in one cs window
      clr_cnt();
      send(16'hF00F, 16, 1'b0);
      chk("t5_data", rx_data, 8'h0F);
      chk("t5_nvalid", 8'(n_valid), 8'd2);
      chk("t5_nfe", 8'(n_fe), 8'd0);

      // reset in the middle of a word
      rx_ready = 1'b0;
      send(16'h005A, 8, 1'b0);
      chk("t6_held", rx_data, 8'h5A);
      cs = 1'b0; sck = 1'b0; step();
      for (int i = 0; i < 4; i++) begin
         sck = 1'b1; mosi = 1'(i % 2); step();
         sck = 1'b0; step();
      end
      assert_reset();
      chk("t6_rst_data", rx_data, 8'h00);
      chk("t6_rst_valid", 8'(rx_valid), 8'd0);
      repeat (3) step();
      reset = 1'b1;
      repeat (2) step();
      rx_ready = 1'b1; clr_cnt();
      send(16'h0080, 8, 1'b0);
      chk("t6_data", rx_data, 8'h80);
      chk("t6_nvalid", 8'(n_valid), 8'd1);
      chk("t6_nfe", 8'(n_fe), 8'd0);

      // random frames, lengths and consumer back-pressure
      rand_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         int r;
         int n;
         r = int'($urandom_range(0, 9));
         n = (r < 2) ? int'($urandom_range(1, 7)) : ((r < 4) ? 16 : 8);
         send(16'($urandom), n, 1'b0);
      end
      rand_ready = 1'b0;
      rx_ready = 1'b1;
      repeat (4) step();
      chk("final_drained", 8'(rx_valid), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side SPI slave that consumes the `sck`/`mosi`/`cs` lines driven by the team's SPI master. It oversamples the three lines in the system clock domain and deserialises MSB-first bytes. Each byte is presented on a valid/ready holding register for the downstream logic, with overrun and short-frame error reporting. It is the stage directly downstream of the SPI master in loopback and board-to-board links.

## Interface
- `DATA_W`, default 8: bits per word; the counter is `$clog2(DATA_W)` wide.
- `SYNC_STAGES`, default 2: synchroniser depth on `sck`/`mosi`/`cs`, minimum 2.
- `clk` in, 1: system clock, single clock domain.
- `reset` in, 1: asynchronous, active-low reset.
- `sck` in, 1: SPI clock; idles high; each level lasts at least 1 `clk`.
- `mosi` in, 1: serial data, MSB first; changes on rising `sck`.
- `cs` in, 1: chip select, active low.
- `rx_data` out, DATA_W: received word in the holding register.
- `rx_valid` out, 1: holding register full.
- `rx_ready` in, 1: consumer accepts `rx_data` when high together with `rx_valid`.
- `overrun` out, 1: 1-clk pulse when a completed word is dropped.
- `frame_err` out, 1: 1-clk pulse when `cs` rises mid-word.
- `busy` out, 1: high while the synchronised `cs` is low.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `overrun`=0, `frame_err`=0, `busy`=0. Synchroniser and edge registers reset to 1 (idle line level), so no edge is detected after reset release. Shift register and bit counter reset to 0.
- Edge detection is done on synchronised signals: `s` is the last synchroniser stage and `p` is `s` delayed by one `clk`.
  - Falling `sck` edge: `sck_s`=0 and `sck_p`=1.
  - CS rise: `cs_s`=1 and `cs_p`=0.
- Data sampling:
  - A falling `sck` edge counts as a data sample only if `cs_s`=0 and `cs_p`=0.
  - This ignores the frame-start falling edge, which coincides with `cs` falling.
  - On a counted edge, `mosi_s` is shifted in at the LSB and the counter increments.
- States:
  - IDLE: `cs_s`=1. Moves to ACTIVE when `cs_s`=0.
  - ACTIVE: shifting.
    - On the DATA_W-th counted edge, the word is complete and the counter wraps to 0. The FSM stays in ACTIVE, so back-to-back words in one `cs` window are supported.
    - On CS rise, the FSM returns to IDLE. If the counter is nonzero, `frame_err` pulses, the partial word is discarded and the counter clears.
- Word completion (the next word is `{shift[DATA_W-2:0], mosi_s}`):
  - `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle: the old word is consumed, the new word is loaded, and `rx_valid` stays 1.
  - `rx_valid`=1 and `rx_ready`=0: the new word is dropped, `rx_data` is unchanged, and `overrun` pulses.
- Handshake without completion: `rx_valid` and `rx_ready` both high clears `rx_valid` on the next edge. `rx_data` holds its value.
- Reset asserted mid-word: all state clears immediately. A partial word never produces `rx_valid` or `frame_err`.

## Timing
- Input path: SYNC_STAGES flops plus one edge register.
- Latency: `rx_valid` rises on clk edge SYNC_STAGES+1 (3 by default), counted from the `clk` edge at which `sck` falls for the final bit at the pins.
- `frame_err`: pulses in the same relative cycle, counted from the `cs` rise.
- Throughput: one bit per 2 `clk` (the master's rate). A new word can complete every 2·DATA_W `clk`.
- `overrun` and `frame_err` are exactly 1 `clk` wide and never asserted together.
- `busy` follows `cs_s` with SYNC_STAGES latency.

## Structure
- Package `spi_pkg`:
  - `SPI_DATA_W = 8`.
  - State enum `spi_rx_state_t` {IDLE, ACTIVE}.
  - Idle line level constant `SPI_IDLE_LVL = 1'b1`.
- Sub-module `spi_sync`: SYNC_STAGES-deep, 1-bit synchroniser with reset value 1. Instantiated three times (`sck`, `mosi`, `cs`).
- Top level contains:
  - edge registers
  - FSM
  - shift register and counter
  - holding register and handshake

## Test plan
- Master-style frame sending 0xA5, `rx_ready` held 1 → `rx_data`=0xA5. `rx_valid` is high for exactly 1 clk, 3 clk after the 8th falling `sck`. No error pulses.
- `cs` rises after 5 counted edges, then a full frame 0x3C → one `frame_err` pulse and no `rx_valid` for the partial word. Then `rx_data`=0x3C.
- `rx_ready`=0, frames 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses once. After `rx_ready`=1 for 1 clk, `rx_valid`=0.
- `rx_ready` pulses in the cycle that 0x22 completes, with 0x11 held → 0x11 consumed, `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- One `cs`-low window with 16 counted edges carrying 0xF0 then 0x0F → two words, in order, no `frame_err`.
- `reset` asserted after 4 bits, released, then frame 0x80 → outputs go to 0 immediately. Afterwards `rx_data`=0x80, with no `frame_err` and no spurious `rx_valid`.
